// File: rtl/jk_pkg.sv
// ---------------------------------------------------------------------------
// jk_pkg
// Shared definitions for the JK vector counter family.
//   MODE_*   : encodings of the 2-bit mode selector
//   jk_next  : single-bit JK flip-flop next-state function
// ---------------------------------------------------------------------------
package jk_pkg;

   localparam logic [1:0] MODE_JK = 2'b00;
   localparam logic [1:0] MODE_UP = 2'b01;
   localparam logic [1:0] MODE_DN = 2'b10;
   localparam logic [1:0] MODE_LD = 2'b11;

   // Classic JK truth table: hold / reset / set / toggle.
   function automatic logic jk_next(input logic q, input logic j, input logic k);
      logic r;
      case ({j, k})
         2'b00:   r = q;
         2'b01:   r = 1'b0;
         2'b10:   r = 1'b1;
         default: r = ~q;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/jk_cell.sv
// ---------------------------------------------------------------------------
// jk_cell
// One JK flip-flop with asynchronous active-high reset to a per-cell value.
// Ports:
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset
//   rst_val : value loaded into q while rst is high
//   j, k    : JK inputs (J=K=0 holds)
//   q       : registered cell output
// ---------------------------------------------------------------------------
module jk_cell
   import jk_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic rst_val,
   input  logic j,
   input  logic k,
   output logic q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= rst_val;
      end else begin
         q <= jk_next(q, j, k);
      end
   end

endmodule

// File: rtl/jk_vector_counter.sv
// ---------------------------------------------------------------------------
// jk_vector_counter
// A WIDTH-bit bank of JK cells usable as raw JK storage, a modulo up/down
// counter or a parallel-load register. Every state change is made by
// driving the J/K inputs of the cells; no bit is ever written directly.
// Parameters:
//   WIDTH     : number of cells (bits of q)
//   MAX_COUNT : top value of the counting modes (1 .. 2**WIDTH-1)
//   RESET_VAL : value forced onto q by reset (<= MAX_COUNT)
// Ports:
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset (q=RESET_VAL, changed=0)
//   en       : update enable; 0 holds every cell and forces tc low
//   mode     : 00 JK, 01 count up, 10 count down, 11 load
//   j, k     : per-bit JK inputs, mode 00 only
//   load_val : value for mode 11
//   q        : cell outputs
//   tc       : combinational terminal count (up at MAX_COUNT, down at 0)
//   changed  : registered, high for one cycle after an edge that changed q
// ---------------------------------------------------------------------------
module jk_vector_counter
   import jk_pkg::*;
#(
   parameter int          WIDTH     = 8,
   parameter int unsigned MAX_COUNT = (2 ** WIDTH) - 1,
   parameter int unsigned RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             changed
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
   localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

   // When the modulus spans the full code space no value can lie above it,
   // so the range check is tied off rather than built as a constant compare.
   localparam bit FULL_RANGE = (MAX_V == {WIDTH{1'b1}});

   logic [WIDTH-1:0] jk_raw;   // what the cells would become in mode 00
   logic [WIDTH-1:0] nxt;      // target value of q for this edge
   logic [WIDTH-1:0] cell_j;
   logic [WIDTH-1:0] cell_k;
   logic             at_max;
   logic             over_max;
   logic             at_zero;

   assign at_max  = (q == MAX_V);
   assign at_zero = (q == '0);

   if (FULL_RANGE) begin : g_full_range
      assign over_max = 1'b0;
   end else begin : g_part_range
      assign over_max = (q > MAX_V);
   end

   always_comb begin
      jk_raw = q;
      for (int i = 0; i < WIDTH; i++) begin
         jk_raw[i] = jk_next(q[i], j[i], k[i]);
      end
   end

   // Target value; used both to derive the cell drive in the arithmetic
   // modes and to detect a change of q for the changed flag.
   always_comb begin
      nxt = q;
      if (en) begin
         case (mode)
            MODE_JK: nxt = jk_raw;
            MODE_UP: nxt = (at_max || over_max) ? '0 : q + WIDTH'(1);
            MODE_DN: nxt = (at_zero || over_max) ? MAX_V : q - WIDTH'(1);
            default: nxt = load_val;
         endcase
      end
   end

   // In mode 00 the external J/K go straight to the cells. Otherwise only
   // the bits that must move are driven: set where nxt=1 & q=0, reset where
   // nxt=0 & q=1, so a plain JK cell reaches any target in one edge.
   always_comb begin
      cell_j = '0;
      cell_k = '0;
      if (en) begin
         if (mode == MODE_JK) begin
            cell_j = j;
            cell_k = k;
         end else begin
            cell_j = nxt & ~q;
            cell_k = ~nxt & q;
         end
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      jk_cell u_cell (
         .clk     (clk),
         .rst     (rst),
         .rst_val (RST_V[i]),
         .j       (cell_j[i]),
         .k       (cell_k[i]),
         .q       (q[i])
      );
   end

   assign tc = en & (((mode == MODE_UP) & at_max) | ((mode == MODE_DN) & at_zero));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         changed <= 1'b0;
      end else begin
         changed <= (nxt != q);
      end
   end

endmodule

// File: tb/tb_jk_vector_counter.sv
// ---------------------------------------------------------------------------
// tb_jk_vector_counter
// Bench for jk_vector_counter: a 4-bit mod-10 instance plus 1-bit and 8-bit
// full-range instances. Expected q/changed values are queued when stimulus
// is applied and popped for comparison after the clock edge.
// ---------------------------------------------------------------------------
module tb_jk_vector_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;

   logic       en4 = 1'b0;
   logic [1:0] mode4 = 2'b00;
   logic [3:0] j4 = '0, k4 = '0, ld4 = '0;
   logic [3:0] q4;
   logic       tc4, ch4;

   logic       en1 = 1'b0;
   logic [1:0] mode1 = 2'b00;
   logic [0:0] j1 = '0, k1 = '0, ld1 = '0;
   logic [0:0] q1;
   logic       tc1, ch1;

   logic       en8 = 1'b0;
   logic [1:0] mode8 = 2'b00;
   logic [7:0] j8 = '0, k8 = '0, ld8 = '0;
   logic [7:0] q8;
   logic       tc8, ch8;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      int         sel;
      logic [7:0] q;
      logic       ch;
      string      nm;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   jk_vector_counter #(.WIDTH(4), .MAX_COUNT(9), .RESET_VAL(0)) dut4 (
      .clk(clk), .rst(rst), .en(en4), .mode(mode4), .j(j4), .k(k4),
      .load_val(ld4), .q(q4), .tc(tc4), .changed(ch4));

   jk_vector_counter #(.WIDTH(1), .MAX_COUNT(1), .RESET_VAL(0)) dut1 (
      .clk(clk), .rst(rst), .en(en1), .mode(mode1), .j(j1), .k(k1),
      .load_val(ld1), .q(q1), .tc(tc1), .changed(ch1));

   jk_vector_counter #(.WIDTH(8), .MAX_COUNT(255), .RESET_VAL(0)) dut8 (
      .clk(clk), .rst(rst), .en(en8), .mode(mode8), .j(j8), .k(k8),
      .load_val(ld8), .q(q8), .tc(tc8), .changed(ch8));

   task automatic obs(input int sel, output logic [7:0] oq, output logic otc, output logic och);
      case (sel)
         1:       begin oq = {7'd0, q1}; otc = tc1; och = ch1; end
         2:       begin oq = q8;         otc = tc8; och = ch8; end
         default: begin oq = {4'd0, q4}; otc = tc4; och = ch4; end
      endcase
   endtask

   // One clock: check tc for the applied inputs, queue the expected post-edge
   // state, let the edge happen, then pop and compare.
   task automatic cycle(input int sel, input logic etc, input logic [7:0] eq,
                        input logic ech, input string nm);
      exp_t       e;
      logic [7:0] oq;
      logic       otc, och;
      #1;
      obs(sel, oq, otc, och);
      n_cmp++;
      if (otc !== etc) begin
         n_err++;
         $display("FAIL %s tc: got %b expected %b", nm, otc, etc);
      end
      e.sel = sel; e.q = eq; e.ch = ech; e.nm = nm;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      obs(e.sel, oq, otc, och);
      n_cmp++;
      if (oq !== e.q) begin
         n_err++;
         $display("FAIL %s q: got %0d expected %0d", e.nm, oq, e.q);
      end
      n_cmp++;
      if (och !== e.ch) begin
         n_err++;
         $display("FAIL %s changed: got %b expected %b", e.nm, och, e.ch);
      end
   endtask

   task automatic test_reset();
      #3 rst = 1'b1;   // between edges
      #1;
      n_cmp++;
      if (q4 !== 4'd0) begin n_err++; $display("FAIL reset_async q: got %0d expected 0", q4); end
      n_cmp++;
      if (ch4 !== 1'b0) begin n_err++; $display("FAIL reset_async changed: got %b expected 0", ch4); end
      en4 = 1'b1; mode4 = 2'b11; ld4 = 4'h7;   // must be ignored while in reset
      @(posedge clk);
      #1;
      n_cmp++;
      if (q4 !== 4'd0) begin n_err++; $display("FAIL reset_hold q: got %0d expected 0", q4); end
      n_cmp++;
      if (q8 !== 8'd0) begin n_err++; $display("FAIL reset_hold q8: got %0d expected 0", q8); end
      n_cmp++;
      if (q1 !== 1'b0) begin n_err++; $display("FAIL reset_hold q1: got %0d expected 0", q1); end
      #2 rst = 1'b0;
   endtask

   task automatic test_count_up();
      en4 = 1'b1; mode4 = 2'b01;
      for (int i = 0; i < 12; i++) begin
         cycle(0, (i % 10) == 9, 8'((i + 1) % 10), 1'b1, $sformatf("up_%0d", i));
      end
   endtask

   task automatic test_count_down();
      logic [3:0] exp_seq [4];
      logic [3:0] cur;
      exp_seq[0] = 4'd1; exp_seq[1] = 4'd0; exp_seq[2] = 4'd9; exp_seq[3] = 4'd8;
      cur = 4'd2;
      mode4 = 2'b10;
      for (int i = 0; i < 4; i++) begin
         cycle(0, cur == 4'd0, {4'd0, exp_seq[i]}, 1'b1, $sformatf("down_%0d", i));
         cur = exp_seq[i];
      end
      mode4 = 2'b11; ld4 = 4'hC;
      cycle(0, 1'b0, 8'h0C, 1'b1, "load_C");
      mode4 = 2'b10;
      cycle(0, 1'b0, 8'd9, 1'b1, "down_recover");
   endtask

   task automatic test_jk();
      mode4 = 2'b11; ld4 = 4'h0;
      cycle(0, 1'b0, 8'd0, 1'b1, "jk_clear");
      mode4 = 2'b00; ld4 = 4'h9;
      j4 = 4'b1111; k4 = 4'b0000;
      cycle(0, 1'b0, 8'b1111, 1'b1, "jk_set");
      j4 = 4'b1010; k4 = 4'b1010;
      cycle(0, 1'b0, 8'b0101, 1'b1, "jk_toggle");
      j4 = 4'b0000; k4 = 4'b0100;
      cycle(0, 1'b0, 8'b0001, 1'b1, "jk_reset_bit");
      j4 = 4'b0000; k4 = 4'b0000;
      cycle(0, 1'b0, 8'b0001, 1'b0, "jk_hold");
   endtask

   task automatic test_load_and_enable();
      mode4 = 2'b11; ld4 = 4'hF; j4 = 4'b0000; k4 = 4'b1111;
      cycle(0, 1'b0, 8'h0F, 1'b1, "load_F");
      mode4 = 2'b01;
      cycle(0, 1'b0, 8'd0, 1'b1, "up_from_oor");
      en4 = 1'b0; mode4 = 2'b10; j4 = 4'b1111; k4 = 4'b0000; ld4 = 4'h5;
      for (int i = 0; i < 3; i++) begin
         cycle(0, 1'b0, 8'd0, 1'b0, $sformatf("en_off_%0d", i));
      end
   endtask

   task automatic test_reset_midcount();
      en4 = 1'b1; mode4 = 2'b01;
      for (int i = 0; i < 7; i++) begin
         cycle(0, 1'b0, 8'(i + 1), 1'b1, $sformatf("pre_rst_%0d", i));
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (q4 !== 4'd0) begin n_err++; $display("FAIL midcount_rst q: got %0d expected 0", q4); end
      n_cmp++;
      if (ch4 !== 1'b0) begin n_err++; $display("FAIL midcount_rst changed: got %b expected 0", ch4); end
      @(posedge clk);
      #2 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle(0, 1'b0, 8'(i + 1), 1'b1, $sformatf("post_rst_%0d", i));
      end
      en4 = 1'b0;
   endtask

   task automatic test_width8();
      logic [7:0] cur;
      en8 = 1'b1; mode8 = 2'b11; ld8 = 8'd250;
      cycle(2, 1'b0, 8'd250, 1'b1, "w8_load");
      mode8 = 2'b01; cur = 8'd250;
      for (int i = 0; i < 7; i++) begin
         cycle(2, cur == 8'd255, cur + 8'd1, 1'b1, $sformatf("w8_up_%0d", i));
         cur = cur + 8'd1;
      end
      mode8 = 2'b10;
      for (int i = 0; i < 3; i++) begin
         cycle(2, cur == 8'd0, cur - 8'd1, 1'b1, $sformatf("w8_dn_%0d", i));
         cur = cur - 8'd1;
      end
      en8 = 1'b0;
   endtask

   task automatic test_width1();
      en1 = 1'b1; mode1 = 2'b01;
      cycle(1, 1'b0, 8'd1, 1'b1, "w1_up_0");
      cycle(1, 1'b1, 8'd0, 1'b1, "w1_up_1");
      cycle(1, 1'b0, 8'd1, 1'b1, "w1_up_2");
      mode1 = 2'b10;
      cycle(1, 1'b0, 8'd0, 1'b1, "w1_dn_0");
      cycle(1, 1'b1, 8'd1, 1'b1, "w1_dn_1");
      cycle(1, 1'b0, 8'd0, 1'b1, "w1_dn_2");
      en1 = 1'b0;
   endtask

   task automatic test_back_to_back();
      // mode switches on consecutive edges, starting from q4 = 3
      en4 = 1'b1;
      mode4 = 2'b11; ld4 = 4'd5;
      cycle(0, 1'b0, 8'd5, 1'b1, "b2b_load");
      mode4 = 2'b10;
      cycle(0, 1'b0, 8'd4, 1'b1, "b2b_down");
      mode4 = 2'b01;
      cycle(0, 1'b0, 8'd5, 1'b1, "b2b_up");
      mode4 = 2'b11; ld4 = 4'd5;
      cycle(0, 1'b0, 8'd5, 1'b0, "b2b_load_same");
      en4 = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_count_up();
      test_count_down();
      test_jk();
      test_load_and_enable();
      test_reset_midcount();
      test_back_to_back();
      test_width8();
      test_width1();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
